// File: rtl/dmem_arbiter_if.sv
// Bundle between the data-memory arbiter, its two requesters (CPU MEM stage and
// debug/loader port) and the single-port dmem instance.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_stall;
  logic                  cpu_rvalid;
  logic [31:0]           cpu_rdata;
  logic                  cpu_err;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [31:0]           dbg_addr;
  logic [31:0]           dbg_wdata;
  logic                  dbg_gnt;
  logic                  dbg_rvalid;
  logic [31:0]           dbg_rdata;
  logic                  dbg_err;

  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [31:0]           mem_din;
  logic [31:0]           mem_dout;

  // Requesters plus the memory instance, seen from outside the arbiter.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_dout,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  mem_we, mem_addr, mem_din
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_dout,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU has default priority, a saturating wait counter
// hands the debug port priority after MAX_WAIT lost cycles.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MAX_WAIT   = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {ArbCpu, ArbDbg} arb_state_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  arb_state_e            state_q, state_d;
  logic [7:0]            wait_q, wait_d;

  logic                  cpu_gnt, dbg_gnt, any_gnt;
  logic [31:0]           win_addr, win_wdata;
  logic                  win_we, win_aligned;

  logic [ADDR_WIDTH-3:0] addr_hold_q;
  logic [31:0]           din_hold_q;
  logic                  owner_valid_q, owner_dbg_q;
  logic                  cpu_err_q, dbg_err_q;

  // Address bits above the dmem range wrap by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cpu_addr[31:ADDR_WIDTH], bus.dbg_addr[31:ADDR_WIDTH]};

  always_comb begin
    dbg_gnt     = bus.dbg_req & (~bus.cpu_req | (state_q == ArbDbg));
    cpu_gnt     = bus.cpu_req & ~dbg_gnt;
    any_gnt     = cpu_gnt | dbg_gnt;
    win_addr    = dbg_gnt ? bus.dbg_addr  : bus.cpu_addr;
    win_wdata   = dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;
    win_we      = dbg_gnt ? bus.dbg_we    : bus.cpu_we;
    win_aligned = (win_addr[1:0] == 2'b00);
  end

  // The priority flip is decided on the counter's next value so that the DBG
  // port wins on the cycle right after its MAX_WAIT-th loss.
  always_comb begin
    wait_d  = wait_q;
    state_d = state_q;
    if (dbg_gnt) begin
      wait_d  = 8'd0;
      state_d = ArbCpu;
    end else if (bus.dbg_req) begin
      if (wait_q < MaxWait) begin
        wait_d = wait_q + 8'd1;
      end
      if (wait_d == MaxWait) begin
        state_d = ArbDbg;
      end
    end else begin
      wait_d  = 8'd0;
      state_d = ArbCpu;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ArbCpu;
      wait_q        <= 8'd0;
      addr_hold_q   <= '0;
      din_hold_q    <= '0;
      owner_valid_q <= 1'b0;
      owner_dbg_q   <= 1'b0;
      cpu_err_q     <= 1'b0;
      dbg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      owner_valid_q <= any_gnt & ~win_we & win_aligned;
      owner_dbg_q   <= dbg_gnt;
      cpu_err_q     <= cpu_gnt & ~win_aligned;
      dbg_err_q     <= dbg_gnt & ~win_aligned;
      if (any_gnt) begin
        addr_hold_q <= win_addr[ADDR_WIDTH-1:2];
        din_hold_q  <= win_wdata;
      end
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;

  // Gated by reset so a request held through reset can never reach the array.
  assign bus.mem_we     = any_gnt & win_we & win_aligned & ~reset;
  assign bus.mem_addr   = any_gnt ? win_addr[ADDR_WIDTH-1:2] : addr_hold_q;
  assign bus.mem_din    = any_gnt ? win_wdata : din_hold_q;

  assign bus.cpu_rvalid = owner_valid_q & ~owner_dbg_q;
  assign bus.dbg_rvalid = owner_valid_q & owner_dbg_q;
  assign bus.cpu_rdata  = bus.mem_dout;
  assign bus.dbg_rdata  = bus.mem_dout;
  assign bus.cpu_err    = cpu_err_q;
  assign bus.dbg_err    = dbg_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of priority, memory contents and returns.
module tb_dmem_arbiter;
  localparam int unsigned AW     = 12;
  localparam int unsigned MW     = 4;
  localparam int unsigned NWORDS = 1 << (AW - 2);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Stand-in for the dmem instance: registered read, write on the edge.
  logic [31:0] dmem [NWORDS];
  always @(posedge clk) begin
    if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= dmem[bus.mem_addr];
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0]   ref_mem [NWORDS];
  int            lost;
  bit            pend_valid, pend_dbg, pend_cerr, pend_derr;
  logic [31:0]   pend_data;
  bit            hold_known;
  logic [AW-3:0] hold_addr;
  logic [31:0]   hold_din;

  // DUT outputs sampled in the last cycle.
  logic        s_cpu_gnt, s_dbg_gnt, s_cpu_stall, s_mem_we;
  logic        s_cpu_rvalid, s_dbg_rvalid, s_cpu_err, s_dbg_err;
  logic [31:0] s_cpu_rdata, s_dbg_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    lost = 0;
    pend_valid = 0; pend_dbg = 0; pend_cerr = 0; pend_derr = 0;
    hold_known = 0;
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dbg(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // return 1 time unit after the rising edge so the caller can drive inputs.
  task automatic cycle();
    bit dw, cw, we, al;
    logic [31:0] a, d;
    int idx;
    @(negedge clk);
    s_cpu_gnt = bus.cpu_gnt;       s_dbg_gnt = bus.dbg_gnt;
    s_cpu_stall = bus.cpu_stall;   s_mem_we = bus.mem_we;
    s_cpu_rvalid = bus.cpu_rvalid; s_dbg_rvalid = bus.dbg_rvalid;
    s_cpu_err = bus.cpu_err;       s_dbg_err = bus.dbg_err;
    s_cpu_rdata = bus.cpu_rdata;   s_dbg_rdata = bus.dbg_rdata;

    dw  = bus.dbg_req && (!bus.cpu_req || lost >= int'(MW));
    cw  = bus.cpu_req && !dw;
    a   = dw ? bus.dbg_addr  : bus.cpu_addr;
    d   = dw ? bus.dbg_wdata : bus.cpu_wdata;
    we  = dw ? bus.dbg_we    : bus.cpu_we;
    al  = (a % 4) == 0;
    idx = int'((a / 4) % NWORDS);

    check("cpu_gnt",   32'(s_cpu_gnt),   32'(cw));
    check("dbg_gnt",   32'(s_dbg_gnt),   32'(dw));
    check("cpu_stall", 32'(s_cpu_stall), 32'(bus.cpu_req && !cw));
    check("mem_we",    32'(s_mem_we),    32'((cw || dw) && we && al));
    if (cw || dw) begin
      check("mem_addr", 32'(bus.mem_addr), 32'(idx));
      check("mem_din",  bus.mem_din, d);
    end else if (hold_known) begin
      check("mem_addr_hold", 32'(bus.mem_addr), 32'(hold_addr));
      check("mem_din_hold",  bus.mem_din, hold_din);
    end
    check("cpu_rvalid", 32'(s_cpu_rvalid), 32'(pend_valid && !pend_dbg));
    check("dbg_rvalid", 32'(s_dbg_rvalid), 32'(pend_valid && pend_dbg));
    check("cpu_err",    32'(s_cpu_err),    32'(pend_cerr));
    check("dbg_err",    32'(s_dbg_err),    32'(pend_derr));
    if (pend_valid) begin
      if (pend_dbg) check("dbg_rdata", s_dbg_rdata, pend_data);
      else          check("cpu_rdata", s_cpu_rdata, pend_data);
    end

    pend_valid = (cw || dw) && !we && al;
    pend_dbg   = dw;
    pend_data  = ref_mem[idx];
    pend_cerr  = cw && !al;
    pend_derr  = dw && !al;
    if ((cw || dw) && we && al) ref_mem[idx] = d;
    if (cw || dw) begin
      hold_known = 1;
      hold_addr  = idx[AW-3:0];
      hold_din   = d;
    end
    if (dw)               lost = 0;
    else if (bus.dbg_req) lost++;
    else                  lost = 0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] hi;
    logic [31:0] off;
    hi  = $urandom();
    off = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
    return (hi & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | off;
  endfunction

  initial begin
    bit cp, dp;
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #2;
    check("rst cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
    check("rst dbg_gnt",    32'(bus.dbg_gnt),    32'd0);
    check("rst mem_we",     32'(bus.mem_we),     32'd0);
    check("rst cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("rst dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    check("rst cpu_err",    32'(bus.cpu_err),    32'd0);
    check("rst dbg_err",    32'(bus.dbg_err),    32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Loader preloads a 16-word window while the CPU is idle.
    for (int i = 0; i < 16; i++) begin
      set_dbg(1, 1, 32'(i * 4), (i == 12) ? 32'h5 : (i == 13) ? 32'h6 : $urandom());
      cycle();
      check("preload dbg_gnt", 32'(s_dbg_gnt), 32'd1);
    end
    set_dbg(0, 0, 0, 0);

    // CPU-only write then read.
    set_cpu(1, 1, 32'h010, 32'hDEADBEEF);
    cycle();
    check("cpu wr gnt",   32'(s_cpu_gnt),   32'd1);
    check("cpu wr stall", 32'(s_cpu_stall), 32'd0);
    set_cpu(1, 0, 32'h010, 0);
    cycle();
    check("cpu rd gnt", 32'(s_cpu_gnt), 32'd1);
    set_cpu(0, 0, 0, 0);
    cycle();
    check("cpu rd rvalid",   32'(s_cpu_rvalid), 32'd1);
    check("cpu rd data",     s_cpu_rdata,       32'hDEADBEEF);
    check("cpu rd dbg_rval", 32'(s_dbg_rvalid), 32'd0);

    // Loader write, then CPU sees it.
    set_dbg(1, 1, 32'h020, 32'h11111111);
    cycle();
    check("dbg wr gnt", 32'(s_dbg_gnt), 32'd1);
    set_dbg(0, 0, 0, 0);
    set_cpu(1, 0, 32'h020, 0);
    cycle();
    set_cpu(0, 0, 0, 0);
    cycle();
    check("ld rd rvalid", 32'(s_cpu_rvalid), 32'd1);
    check("ld rd data",   s_cpu_rdata,       32'h11111111);
    check("ld rd dbgval", 32'(s_dbg_rvalid), 32'd0);

    // Misaligned write is granted but suppressed.
    set_cpu(1, 1, 32'h013, 32'hAAAAAAAA);
    cycle();
    check("mis gnt",    32'(s_cpu_gnt), 32'd1);
    check("mis mem_we", 32'(s_mem_we),  32'd0);
    set_cpu(1, 0, 32'h010, 0);
    cycle();
    check("mis err", 32'(s_cpu_err), 32'd1);
    set_cpu(0, 0, 0, 0);
    cycle();
    check("mis rd data", s_cpu_rdata, 32'hDEADBEEF);

    // Back-to-back reads from both ports.
    set_dbg(1, 0, 32'h030, 0);
    cycle();
    set_dbg(0, 0, 0, 0);
    set_cpu(1, 0, 32'h034, 0);
    cycle();
    check("b2b dbg rvalid", 32'(s_dbg_rvalid), 32'd1);
    check("b2b dbg data",   s_dbg_rdata,       32'h5);
    set_cpu(0, 0, 0, 0);
    cycle();
    check("b2b cpu rvalid", 32'(s_cpu_rvalid), 32'd1);
    check("b2b cpu data",   s_cpu_rdata,       32'h6);
    check("b2b dbg rval0",  32'(s_dbg_rvalid), 32'd0);

    // Continuous contention.
    set_cpu(1, 0, 32'h000, 0);
    set_dbg(1, 0, 32'h004, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("cont dbg_gnt",   32'(s_dbg_gnt),   32'(i == 4 || i == 9));
      check("cont cpu_stall", 32'(s_cpu_stall), 32'(i == 4 || i == 9));
    end
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);
    cycle();

    // Build up DBG wait, then reset with a CPU read return pending.
    set_cpu(1, 0, 32'h010, 0);
    set_dbg(1, 0, 32'h014, 0);
    cycle();
    cycle();
    reset = 1'b1;
    set_cpu(1, 1, 32'h010, 32'h55555555);
    set_dbg(0, 0, 0, 0);
    @(negedge clk);
    check("mid rst cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("mid rst mem_we",     32'(bus.mem_we),     32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid rst mem_we2", 32'(bus.mem_we), 32'd0);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_dbg(1, 0, 32'h014, 0);
    cycle();
    check("post rst dbg gnt", 32'(s_dbg_gnt), 32'd1);
    set_cpu(1, 0, 32'h010, 0);
    set_dbg(1, 0, 32'h014, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("post rst cont dbg", 32'(s_dbg_gnt), 32'(i == 4));
    end
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);
    cycle();
    check("post rst rd data", s_dbg_rdata, ref_mem[5]);

    // Random traffic, requests held until granted; DBG may withdraw.
    cp = 0;
    dp = 0;
    for (int n = 0; n < 400; n++) begin
      if (!cp && $urandom_range(0, 9) < 6) begin
        cp = 1;
        set_cpu(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
      end
      if (!dp && $urandom_range(0, 9) < 3) begin
        dp = 1;
        set_dbg(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
      end else if (dp && $urandom_range(0, 15) == 0) begin
        dp = 0;
        bus.dbg_req = 1'b0;
      end
      cycle();
      if (s_cpu_gnt === 1'b1) begin
        cp = 0;
        bus.cpu_req = 1'b0;
      end
      if (s_dbg_gnt === 1'b1) begin
        dp = 0;
        bus.dbg_req = 1'b0;
      end
    end
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the pipeline MEM stage (CPU port) and the debug/program-loader port (DBG port). The CPU has default priority. A wait counter guarantees the DBG port a grant after a bounded number of lost cycles. Sits between the memory stage and the dmem instance; drives dmem's write-enable, word address and write data, and returns read data with a valid strobe to the winning requester.

## Interface

- ADDR_WIDTH, 12: byte-address width of dmem; word address is addr[ADDR_WIDTH-1:2].
- MAX_WAIT, 4: cycles the DBG port may lose before it takes priority; legal range 1..255.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline
- cpu_rvalid  out  1  read data valid, one cycle after a read grant
- cpu_rdata  out  32  read data; meaningful only when cpu_rvalid
- cpu_err  out  1  misaligned-access pulse, one cycle after the grant
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err: same widths and meaning for the DBG port (no stall output)
- mem_we  out  1  dmem write enable
- mem_addr  out  ADDR_WIDTH-2  dmem word address
- mem_din  out  32  dmem write data
- mem_dout  in  32  dmem read data, registered by dmem, valid the cycle after the address

## Operation

- **Priority state:** ARB_CPU or ARB_DBG. Reset state is ARB_CPU.
  - ARB_CPU: CPU wins when both ports request.
  - ARB_DBG: DBG wins when both ports request.
- **Grant:** combinational from req and state. At most one grant per cycle. A sole requester is always granted.
- **Wait counter** (8 bits):
  - Increments, saturating at MAX_WAIT, on each cycle with dbg_req & ~dbg_gnt.
  - Clears on dbg_gnt.
  - When it is MAX_WAIT and dbg_req is still pending, the next state is ARB_DBG.
  - The cycle dbg_gnt asserts, the next state is ARB_CPU.
  - If dbg_req drops without a grant, the counter clears and the state returns to ARB_CPU.
- **Memory drive:**
  - mem_addr = winner_addr[ADDR_WIDTH-1:2].
  - mem_din = winner_wdata.
  - mem_we = grant & winner_we & aligned.
  - With no grant: mem_we = 0 and mem_addr/mem_din hold their last value.
- **Alignment:** winner_addr[1:0] != 0 is misaligned.
  - The request is still granted and consumes the slot.
  - The write is suppressed and no rvalid is produced.
  - The matching err output pulses the next cycle.
- **Read return:**
  - Registered owner tag plus valid bit, set on an aligned read grant.
  - The next cycle pulses the owner's rvalid.
  - rdata = mem_dout on both ports (comb pass-through). Consumers qualify it with rvalid.
- **Back-to-back:** a new grant may issue every cycle. Read return from cycle N overlaps grant N+1 without conflict.
- **Out-of-range addresses:** bits above ADDR_WIDTH-1 are ignored (wrap).

## Timing

- **Reset values:**
  - Registered: state ARB_CPU, wait counter 0, owner valid 0, all rvalid/err 0.
  - Combinational: gnt 0 and mem_we 0 while no req.
- **Latencies:**
  - Grant: 0 cycles (same cycle as req).
  - Write: commits at the clock edge ending the grant cycle.
  - Read data: rvalid exactly 1 cycle after grant.
  - err: 1 cycle after grant.
- **Worst-case DBG latency** under continuous CPU requests: MAX_WAIT lost cycles, granted on cycle MAX_WAIT+1 of waiting.
- **Worst CPU stall from arbitration:** 1 cycle per MAX_WAIT+1 cycles.
- **Reset mid-operation:** a pending rvalid/err is cancelled, the counter clears, and the state returns to ARB_CPU. No write occurs while reset is asserted.
- **Simultaneous events:** dbg_req dropping while the counter saturates means no state change to ARB_DBG.

## Test plan

- **CPU-only traffic:** CPU write 0xDEADBEEF to 0x010, then read 0x010 → cpu_gnt both cycles, cpu_stall 0, cpu_rvalid the cycle after the read with cpu_rdata 0xDEADBEEF, dbg outputs 0.
- **Contention, MAX_WAIT=4:** cpu_req and dbg_req held high from cycle 0 → cpu_gnt cycles 0–3, dbg_gnt cycle 4 with cpu_stall=1 in cycle 4, cpu_gnt again cycles 5–8, dbg_gnt cycle 9.
- **DBG loader writes 0x11111111 to 0x020 while CPU is idle** → dbg_gnt same cycle; a subsequent CPU read of 0x020 returns 0x11111111 with cpu_rvalid only (dbg_rvalid 0).
- **Misaligned CPU write to 0x013 with data 0xAAAAAAAA** → cpu_gnt 1, mem_we 0, cpu_err pulse next cycle; a read of 0x010 returns the prior contents unchanged.
- **Back-to-back reads:** DBG reads 0x030 in cycle N and CPU reads 0x034 in cycle N+1 (memory preloaded 0x30→0x5, 0x34→0x6) → dbg_rvalid in N+1 with data 0x5, cpu_rvalid in N+2 with data 0x6.
- **Reset mid-operation:** assert reset the cycle after a CPU read grant → cpu_rvalid stays 0; after release, the counter and state are back to their reset values and a lone dbg_req is granted immediately.
